pc_fetch_unit: RTL and testbench

Instruction-fetch stage for the single-cycle MIPS core, directly upstream of the control unit. Holds the program counter, fetches each instruction from instruction memory over a req/ack handshake, and presents the instruction word to the decoder and datapath with a one-cycle commit strobe. At commit it takes the decoded 2-bit PC-source select and computes the next PC: sequential, branch, register jump, or absolute jump.

---
 rtl/pc_fetch_unit.sv | 136 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Instruction fetch: holds the PC, fetches over Imem req/ack, presents Inst for one EXEC cycle.
// Latency: 2 cycles per instruction minimum (FETCH with ack, then EXEC); +1 per un-acked cycle.
// Backpressure: Imem_req held with stable Imem_addr until Imem_ack; ERR is terminal until reset.
//
// Ports:
//   Clk, Clrn        clock, asynchronous active-low reset
//   Pcsrc, Ra        next-PC select and jr target, used only in EXEC
//   Imem_req/addr    fetch request and address (address = Pc)
//   Imem_ack/rdata   memory accept and same-cycle instruction word
//   Inst, Pc, Pc4    registered instruction, its address, and Pc+4
//   Inst_valid       high for the EXEC cycle only
//   Icount           retired-instruction counter
//   Misalign         sticky: jr target had nonzero low bits
//   Fetch_err        sticky: fetch timed out
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic [1:0]  Pcsrc,
  input  logic [31:0] Ra,
  output logic        Imem_req,
  output logic [31:0] Imem_addr,
  input  logic        Imem_ack,
  input  logic [31:0] Imem_rdata,
  output logic [31:0] Inst,
  output logic [31:0] Pc,
  output logic [31:0] Pc4,
  output logic        Inst_valid,
  output logic [31:0] Icount,
  output logic        Misalign,
  output logic        Fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  // Counter only needs to reach TIMEOUT-1.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_pc;
  logic [31:0]     r_inst;
  logic [31:0]     r_icount;
  logic [CW-1:0]   r_wait;
  logic            r_misalign;
  logic            r_fetch_err;

  logic            w_fetch;
  logic            w_exec;
  logic            w_timeout;
  logic [31:0]     w_pc4;
  logic [31:0]     w_br_off;
  logic [31:0]     w_pc_nxt;

  assign w_fetch   = (r_state == S_FETCH);
  assign w_exec    = (r_state == S_EXEC);
  // Last allowed un-acked cycle; an ack in this same cycle still wins.
  assign w_timeout = (TIMEOUT != 0) && (r_wait == WAIT_LAST);
  assign w_pc4     = r_pc + 32'd4;
  assign w_br_off  = {{14{r_inst[15]}}, r_inst[15:0], 2'b00};

  always_comb begin
    w_pc_nxt = w_pc4;
    case (Pcsrc)
      2'b00:   w_pc_nxt = w_pc4;
      2'b01:   w_pc_nxt = w_pc4 + w_br_off;
      2'b10:   w_pc_nxt = {Ra[31:2], 2'b00};
      2'b11:   w_pc_nxt = {w_pc4[31:28], r_inst[25:0], 2'b00};
      default: w_pc_nxt = w_pc4;
    endcase
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (Imem_ack)       w_state_nxt = S_EXEC;
        else if (w_timeout) w_state_nxt = S_ERR;
      end
      S_EXEC:  w_state_nxt = S_FETCH;
      S_ERR:   w_state_nxt = S_ERR;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      r_pc        <= RESET_PC;
      r_inst      <= 32'd0;
      r_icount    <= 32'd0;
      r_wait      <= '0;
      r_misalign  <= 1'b0;
      r_fetch_err <= 1'b0;
    end else begin
      if (w_fetch) begin
        if (Imem_ack) begin
          r_inst <= Imem_rdata;
          r_wait <= '0;
        end else begin
          r_wait <= r_wait + CW'(1);
          if (w_timeout) r_fetch_err <= 1'b1;
        end
      end
      if (w_exec) begin
        r_pc     <= w_pc_nxt;
        r_icount <= r_icount + 32'd1;
        if (Pcsrc == 2'b10 && Ra[1:0] != 2'b00) r_misalign <= 1'b1;
      end
    end
  end

  assign Imem_req   = w_fetch;
  assign Imem_addr  = r_pc;
  assign Inst       = r_inst;
  assign Pc         = r_pc;
  assign Pc4        = w_pc4;
  assign Inst_valid = w_exec;
  assign Icount     = r_icount;
  assign Misalign   = r_misalign;
  assign Fetch_err  = r_fetch_err;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: reference model tracks PC, retired count and misalign flag.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: memory ack delays are chosen per fetch by the bench.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          TMO    = 4;

  logic        Clk;
  logic        Clrn;
  logic [1:0]  Pcsrc;
  logic [31:0] Ra;
  logic        Imem_req;
  logic [31:0] Imem_addr;
  logic        Imem_ack;
  logic [31:0] Imem_rdata;
  logic [31:0] Inst;
  logic [31:0] Pc;
  logic [31:0] Pc4;
  logic        Inst_valid;
  logic [31:0] Icount;
  logic        Misalign;
  logic        Fetch_err;

  pc_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
    .Clk        (Clk),
    .Clrn       (Clrn),
    .Pcsrc      (Pcsrc),
    .Ra         (Ra),
    .Imem_req   (Imem_req),
    .Imem_addr  (Imem_addr),
    .Imem_ack   (Imem_ack),
    .Imem_rdata (Imem_rdata),
    .Inst       (Inst),
    .Pc         (Pc),
    .Pc4        (Pc4),
    .Inst_valid (Inst_valid),
    .Icount     (Icount),
    .Misalign   (Misalign),
    .Fetch_err  (Fetch_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_pc;
  logic [31:0] m_icount;
  logic        m_mis;

  // Next PC from the instruction-set rules, using plain arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] inst,
                                           input logic [1:0] src, input logic [31:0] ra);
    int off;
    off = $signed(inst[15:0]);
    case (src)
      2'd0:    return pc + 32'd4;
      2'd1:    return pc + 32'd4 + 32'(off * 4);
      2'd2:    return ra & 32'hFFFF_FFFC;
      default: return ((pc + 32'd4) & 32'hF000_0000) | ((inst & 32'h03FF_FFFF) << 2);
    endcase
  endfunction

  task automatic model_reset();
    m_pc     = RST_PC;
    m_icount = 32'd0;
    m_mis    = 1'b0;
  endtask

  // Pulse reset; returns at the falling edge of the first FETCH cycle.
  task automatic do_reset();
    @(negedge Clk);
    Clrn     = 1'b0;
    Imem_ack = 1'b0;
    @(negedge Clk);
    Clrn = 1'b1;
    model_reset();
    @(negedge Clk);
  endtask

  // One instruction: `delay` un-acked FETCH cycles, an ack cycle, then EXEC.
  // Entered and left at the falling edge of a FETCH cycle.
  task automatic run_instr(input logic [31:0] inst, input logic [1:0] src,
                           input logic [31:0] ra, input int delay);
    for (int d = 0; d <= delay; d++) begin
      checks++;
      if ({Imem_req, Inst_valid} !== 2'b10) begin
        failures++;
        $display("FAIL fetch_req_valid got=%b exp=10 cyc=%0d", {Imem_req, Inst_valid}, d);
      end
      checks++;
      if (Imem_addr !== m_pc) begin
        failures++;
        $display("FAIL fetch_addr got=%h exp=%h cyc=%0d", Imem_addr, m_pc, d);
      end
      Imem_ack   = (d == delay);
      Imem_rdata = (d == delay) ? inst : $urandom;
      Pcsrc      = 2'($urandom_range(0, 3));
      Ra         = $urandom;
      @(negedge Clk);
    end
    Imem_ack   = 1'($urandom_range(0, 1));
    Imem_rdata = $urandom;
    checks++;
    if ({Imem_req, Inst_valid} !== 2'b01) begin
      failures++;
      $display("FAIL exec_req_valid got=%b exp=01", {Imem_req, Inst_valid});
    end
    checks++;
    if (Inst !== inst) begin
      failures++;
      $display("FAIL exec_inst got=%h exp=%h", Inst, inst);
    end
    checks++;
    if (Pc !== m_pc || Pc4 !== m_pc + 32'd4) begin
      failures++;
      $display("FAIL exec_pc got=%h/%h exp=%h/%h", Pc, Pc4, m_pc, m_pc + 32'd4);
    end
    Pcsrc = src;
    Ra    = ra;
    @(negedge Clk);
    m_pc     = ref_next(m_pc, inst, src, ra);
    m_icount = m_icount + 32'd1;
    if (src == 2'd2 && ra[1:0] != 2'b00) m_mis = 1'b1;
    checks++;
    if (Pc !== m_pc) begin
      failures++;
      $display("FAIL next_pc got=%h exp=%h src=%0d", Pc, m_pc, src);
    end
    checks++;
    if (Icount !== m_icount || Misalign !== m_mis || Fetch_err !== 1'b0) begin
      failures++;
      $display("FAIL retire_state got=%0d/%b/%b exp=%0d/%b/0", Icount, Misalign, Fetch_err,
               m_icount, m_mis);
    end
  endtask

  task automatic test_reset();
    Clrn = 1'b0; Pcsrc = 2'd0; Ra = 32'd0; Imem_ack = 1'b0; Imem_rdata = 32'd0;
    #12;
    checks++;
    if ({Imem_req, Inst_valid, Misalign, Fetch_err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000", {Imem_req, Inst_valid, Misalign, Fetch_err});
    end
    checks++;
    if (Pc !== RST_PC || Inst !== 32'd0 || Icount !== 32'd0) begin
      failures++;
      $display("FAIL reset_regs got=%h/%h/%h exp=%h/0/0", Pc, Inst, Icount, RST_PC);
    end
    @(negedge Clk);
    Clrn = 1'b1;
    model_reset();
    #1;
    checks++;
    if (Imem_req !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_req got=%b exp=0", Imem_req);
    end
    @(negedge Clk);
    checks++;
    if (Imem_req !== 1'b1 || Imem_addr !== RST_PC) begin
      failures++;
      $display("FAIL first_req got=%b/%h exp=1/%h", Imem_req, Imem_addr, RST_PC);
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) run_instr($urandom, 2'd0, $urandom, 0);
    checks++;
    if (Icount !== 32'd4 || Pc !== 32'h10) begin
      failures++;
      $display("FAIL seq_count got=%0d/%h exp=4/00000010", Icount, Pc);
    end
  endtask

  task automatic test_branch();
    run_instr($urandom, 2'd2, 32'h0000_0100, 0);
    run_instr({$urandom_range(0, 65535), 16'hFFFE}, 2'd1, $urandom, 0);
    checks++;
    if (Pc !== 32'h0000_00FC) begin
      failures++;
      $display("FAIL branch_back got=%h exp=000000fc", Pc);
    end
    run_instr($urandom, 2'd2, 32'h0000_0100, 1);
    run_instr({$urandom_range(0, 65535), 16'h0003}, 2'd1, $urandom, 0);
    checks++;
    if (Pc !== 32'h0000_0110) begin
      failures++;
      $display("FAIL branch_fwd got=%h exp=00000110", Pc);
    end
  endtask

  task automatic test_jump();
    run_instr($urandom, 2'd2, 32'h1000_0040, 0);
    run_instr({6'h02, 26'h0000010}, 2'd3, $urandom, 0);
    checks++;
    if (Pc !== 32'h1000_0040) begin
      failures++;
      $display("FAIL jump_abs got=%h exp=10000040", Pc);
    end
    run_instr($urandom, 2'd2, 32'h0000_2002, 0);
    checks++;
    if (Pc !== 32'h0000_2000 || Misalign !== 1'b1) begin
      failures++;
      $display("FAIL jr_misalign got=%h/%b exp=00002000/1", Pc, Misalign);
    end
    for (int i = 0; i < 3; i++) run_instr($urandom, 2'd0, $urandom, 0);
    checks++;
    if (Misalign !== 1'b1) begin
      failures++;
      $display("FAIL misalign_sticky got=%b exp=1", Misalign);
    end
  endtask

  task automatic test_wait_states();
    run_instr($urandom, 2'd0, $urandom, 3);
    run_instr($urandom, 2'd1, $urandom, 2);
  endtask

  task automatic test_wrap();
    run_instr($urandom, 2'd2, 32'hFFFF_FFFC, 0);
    run_instr($urandom, 2'd0, $urandom, 1);
    checks++;
    if (Pc !== 32'h0000_0000) begin
      failures++;
      $display("FAIL pc_wrap got=%h exp=00000000", Pc);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra;
      ra = $urandom;
      if ($urandom_range(0, 1) == 0) ra[1:0] = 2'b00;
      run_instr($urandom, 2'($urandom_range(0, 3)), ra, $urandom_range(0, TMO - 1));
    end
  endtask

  task automatic test_timeout();
    do_reset();
    checks++;
    if (Misalign !== 1'b0 || Fetch_err !== 1'b0 || Icount !== 32'd0) begin
      failures++;
      $display("FAIL reset_clears got=%b/%b/%0d exp=0/0/0", Misalign, Fetch_err, Icount);
    end
    run_instr($urandom, 2'd0, $urandom, 0);
    run_instr($urandom, 2'd0, $urandom, 1);
    for (int i = 0; i < TMO; i++) begin
      checks++;
      if (Imem_req !== 1'b1 || Fetch_err !== 1'b0) begin
        failures++;
        $display("FAIL pre_timeout got=%b/%b exp=1/0 cyc=%0d", Imem_req, Fetch_err, i);
      end
      Imem_ack = 1'b0;
      @(negedge Clk);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({Imem_req, Inst_valid, Fetch_err} !== 3'b001 || Icount !== m_icount || Pc !== m_pc) begin
        failures++;
        $display("FAIL err_hold got=%b/%0d/%h exp=001/%0d/%h", {Imem_req, Inst_valid, Fetch_err},
                 Icount, Pc, m_icount, m_pc);
      end
      Imem_ack   = 1'b1;
      Imem_rdata = $urandom;
      @(negedge Clk);
    end
    Imem_ack = 1'b0;
    do_reset();
    checks++;
    if (Pc !== RST_PC || Fetch_err !== 1'b0 || Imem_req !== 1'b1) begin
      failures++;
      $display("FAIL err_recover got=%h/%b/%b exp=%h/0/1", Pc, Fetch_err, Imem_req, RST_PC);
    end
  endtask

  task automatic test_reset_mid_exec();
    run_instr($urandom, 2'd0, $urandom, 0);
    Imem_ack   = 1'b1;
    Imem_rdata = {6'h03, 26'($urandom_range(1, 32'h03FF_FFFF))};
    @(negedge Clk);
    Pcsrc = 2'd3;
    Ra    = $urandom;
    #2;
    Clrn = 1'b0;
    #1;
    checks++;
    if (Pc !== RST_PC || Inst !== 32'd0 || Icount !== 32'd0) begin
      failures++;
      $display("FAIL midreset_regs got=%h/%h/%0d exp=%h/0/0", Pc, Inst, Icount, RST_PC);
    end
    checks++;
    if ({Imem_req, Inst_valid, Misalign, Fetch_err} !== 4'b0000) begin
      failures++;
      $display("FAIL midreset_flags got=%b exp=0000", {Imem_req, Inst_valid, Misalign, Fetch_err});
    end
    @(negedge Clk);
    Clrn = 1'b1;
    model_reset();
    #1;
    checks++;
    if (Imem_req !== 1'b0) begin
      failures++;
      $display("FAIL midreset_idle got=%b exp=0", Imem_req);
    end
    @(negedge Clk);
    checks++;
    if (Imem_req !== 1'b1 || Pc !== RST_PC || Inst !== 32'd0) begin
      failures++;
      $display("FAIL midreset_refetch got=%b/%h/%h exp=1/%h/0", Imem_req, Pc, Inst, RST_PC);
    end
    run_instr($urandom, 2'd0, $urandom, 0);
    run_instr($urandom, 2'd3, $urandom, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_wait_states();
    test_wrap();
    test_random();
    test_timeout();
    test_reset_mid_exec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
